btn_digit_editor: RTL
=====================

BTN_DIGIT_EDITOR -- requirements
Module: btn_digit_editor

Interface
REQ-001 Parameter DIGITS, default 4, number of independent digit channels (1..8).
REQ-002 Parameter WIDTH, default 4, bits per digit.
REQ-003 Parameter MAX_VAL, default 9, largest digit value; SHALL satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-004 Parameter REPEAT_DLY, default 8, held cycles before auto-repeat starts (>=1).
REQ-005 Parameter REPEAT_PER, default 2, cycles between auto-repeat steps (>=1).
REQ-006 clk  input  1  sole clock, rising edge; one clock, all state in this domain.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 btn_up  input  DIGITS  per-digit increment button, asynchronous, active-high.
REQ-009 btn_dn  input  DIGITS  per-digit decrement button, asynchronous, active-high.
REQ-010 sat_mode  input  1  1 = saturate at 0/MAX_VAL, 0 = wrap-around.
REQ-011 clr  input  1  synchronous clear of all digits to 0.
REQ-012 num  output  DIGITS*WIDTH  registered digit values, digit i at [i*WIDTH +: WIDTH].
REQ-013 changed  output  DIGITS  registered one-cycle pulse per digit whose value changed.

Function
REQ-014 Each button bit SHALL pass a 2-flop synchroniser; all decisions use synchronised values.
REQ-015 Per digit, dir = +1 if up&~dn, -1 if dn&~up, else 0; both pressed SHALL count as none.
REQ-016 Per-digit FSM states IDLE, DELAY, REPEAT; reset state IDLE.
REQ-017 IDLE: dir!=0 -> issue one step, load counter, go DELAY; else stay.
REQ-018 DELAY: dir==0 or dir changed -> IDLE, no step; counter reaches REPEAT_DLY -> step, go REPEAT.
REQ-019 REPEAT: dir==0 or dir changed -> IDLE, no step; otherwise one step every REPEAT_PER cycles.
REQ-020 A direction reversal SHALL pass through IDLE; the new direction steps on the following cycle.
REQ-021 First step SHALL appear on num on the 3rd rising clk edge after the button is stable high.
REQ-022 Wrap mode: MAX_VAL + 1 -> 0, 0 - 1 -> MAX_VAL.
REQ-023 Saturate mode: increment at MAX_VAL and decrement at 0 SHALL hold value, changed stays 0.
REQ-024 clr SHALL override all steps that cycle, zero every digit, force all FSMs to IDLE.
REQ-025 changed[i] SHALL be asserted in the same cycle num digit i takes a new value, else 0.
REQ-026 Digit arithmetic SHALL be mod (MAX_VAL+1) in WIDTH bits; no out-of-range value ever on num.

Reset
REQ-027 rst_n low SHALL immediately set num=0, changed=0, all FSMs IDLE, counters and synchronisers 0.
REQ-028 Reset mid-hold: after release, a still-held button SHALL be treated as a new press (REQ-017, REQ-021).

Configuration
REQ-029 Macro BTN_DIGIT_CARRY_EN defined: in wrap mode, wrap of digit i SHALL carry (+1) or borrow (-1) into digit i+1 in the same cycle; carry out of the top digit is discarded.
REQ-030 With BTN_DIGIT_CARRY_EN, digit i+1 applies own step plus incoming carry as a net delta in -2..+2, wrapping once mod (MAX_VAL+1), and itself propagates carry if it wraps.
REQ-031 With BTN_DIGIT_CARRY_EN, saturate mode SHALL saturate the whole number (all digits MAX_VAL or all 0) and generate no carry.
REQ-032 Macro undefined: digits fully independent, no carry logic synthesised.

Verification (DIGITS=4, WIDTH=4, MAX_VAL=9, REPEAT_DLY=8, REPEAT_PER=2)
REQ-033 Reset, pulse btn_up[0] 3 cycles -> num=16'h0001, changed[0] one pulse on 3rd edge.
REQ-034 Hold btn_dn[1] 20 cycles, wrap mode -> digit1 9,8,7,... one step then repeat every 2 cycles after 8.
REQ-035 sat_mode=1, digit0=9, press btn_up[0] -> digit0 stays 9, changed[0]=0.
REQ-036 btn_up[2]&btn_dn[2] together 10 cycles -> digit2 unchanged, FSM IDLE throughout.
REQ-037 CARRY_EN, num=16'h0099, press btn_up[0] -> num=16'h0100; clr during hold -> num=0, changed=0.
REQ-038 rst_n low mid-REPEAT while holding btn_up[3] -> num=0 immediately; after release first step after 3 edges.

Source files
------------

// File: rtl/btn_digit_editor.sv
// btn_digit_editor: per-digit up/down button editor with auto-repeat.
// Each digit has its own 2-flop button synchroniser and an
// IDLE/DELAY/REPEAT FSM. Digit values are kept in 0..MAX_VAL and either
// wrap or saturate, as selected by sat_mode_i.
// Optional feature: define BTN_DIGIT_CARRY_EN to make wrapping digits carry
// into, or borrow from, the next digit up (wrap mode only).
module btn_digit_editor #(
    parameter int DIGITS     = 4,
    parameter int WIDTH      = 4,
    parameter int MAX_VAL    = 9,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIGITS-1:0]       btn_up_i,
    input  logic [DIGITS-1:0]       btn_dn_i,
    input  logic                    sat_mode_i,
    input  logic                    clr_i,
    output logic [DIGITS*WIDTH-1:0] num_o,
    output logic [DIGITS-1:0]       changed_o
);

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PER);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    // Direction encoding: bit0 = up, bit1 = down; both set never occurs.
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [DIGITS-1:0]       up_meta_q, up_sync_q, dn_meta_q, dn_sync_q;
    state_t                  state_q [DIGITS];
    state_t                  state_d [DIGITS];
    logic [CNT_W-1:0]        cnt_q   [DIGITS];
    logic [CNT_W-1:0]        cnt_d   [DIGITS];
    logic [1:0]              dir_q   [DIGITS];
    logic [1:0]              dir_d   [DIGITS];
    logic [1:0]              dir_s   [DIGITS];
    logic [DIGITS-1:0]       step_s;
    logic [DIGITS*WIDTH-1:0] num_q, num_d;
    logic [DIGITS-1:0]       changed_q, changed_d;

    // Two-flop synchronisers for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_meta_q <= '0;
            up_sync_q <= '0;
            dn_meta_q <= '0;
            dn_sync_q <= '0;
        end else begin
            up_meta_q <= btn_up_i;
            up_sync_q <= up_meta_q;
            dn_meta_q <= btn_dn_i;
            dn_sync_q <= dn_meta_q;
        end
    end

    // Per-digit requested direction; pressing both buttons counts as none.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            dir_s[i] = {dn_sync_q[i] & ~up_sync_q[i], up_sync_q[i] & ~dn_sync_q[i]};
        end
    end

    // Per-digit auto-repeat FSM: next state, counter, latched direction and step strobe.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            dir_d[i]   = dir_q[i];
            step_s[i]  = 1'b0;
            if (clr_i) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                dir_d[i]   = DIR_NONE;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (dir_s[i] != DIR_NONE) begin
                            step_s[i]  = 1'b1;
                            cnt_d[i]   = ONE_C;
                            dir_d[i]   = dir_s[i];
                            state_d[i] = ST_DELAY;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if ((dir_s[i] == DIR_NONE) || (dir_s[i] != dir_q[i])) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                            dir_d[i]   = DIR_NONE;
                        end else if (cnt_q[i] >= DLY_C) begin
                            step_s[i]  = 1'b1;
                            cnt_d[i]   = ONE_C;
                            state_d[i] = ST_REPEAT;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + ONE_C;
                        end
                    end
                    ST_REPEAT: begin
                        if ((dir_s[i] == DIR_NONE) || (dir_s[i] != dir_q[i])) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                            dir_d[i]   = DIR_NONE;
                        end else if (cnt_q[i] >= PER_C) begin
                            step_s[i]  = 1'b1;
                            cnt_d[i]   = ONE_C;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + ONE_C;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                        dir_d[i]   = DIR_NONE;
                    end
                endcase
            end
        end
    end

    // FSM state, counter and latched-direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                dir_q[i]   <= DIR_NONE;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                dir_q[i]   <= dir_d[i];
            end
        end
    end

    // Digit arithmetic: apply the step (plus the incoming carry when enabled),
    // then clamp or wrap back into 0..MAX_VAL; clr wins over everything.
    always_comb begin : digit_next
        int v_s;
        int s_s;
        int delta_s;
`ifdef BTN_DIGIT_CARRY_EN
        int carry_s;
        carry_s = 0;
`endif
        num_d     = num_q;
        changed_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v_s     = int'(num_q[i*WIDTH +: WIDTH]);
            delta_s = (!step_s[i]) ? 0 : ((dir_s[i] == DIR_UP) ? 1 : -1);
`ifdef BTN_DIGIT_CARRY_EN
            delta_s = delta_s + (sat_mode_i ? 0 : carry_s);
`endif
            s_s = v_s + delta_s;
`ifdef BTN_DIGIT_CARRY_EN
            // Net delta is within -2..+2, so a single wrap is always enough.
            carry_s = sat_mode_i ? 0 : ((s_s > MAX_VAL) ? 1 : ((s_s < 0) ? -1 : 0));
`endif
            s_s = sat_mode_i
                ? ((s_s > MAX_VAL) ? MAX_VAL : ((s_s < 0) ? 0 : s_s))
                : ((s_s > MAX_VAL) ? (s_s - (MAX_VAL + 1)) : ((s_s < 0) ? (s_s + MAX_VAL + 1) : s_s));
            num_d[i*WIDTH +: WIDTH] = s_s[WIDTH-1:0];
            changed_d[i]            = (s_s != v_s);
        end
        if (clr_i) begin
            num_d     = '0;
            changed_d = '0;
        end else begin
            num_d     = num_d;
            changed_d = changed_d;
        end
    end

    // Registered digit values and per-digit change pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= '0;
            changed_q <= '0;
        end else begin
            num_q     <= num_d;
            changed_q <= changed_d;
        end
    end

    assign num_o     = num_q;
    assign changed_o = changed_q;

endmodule
